// File: rtl/dual_port_ram_param.sv
// rtl/dual_port_ram_param.sv - parametrised dual-port RAM with byte enables, init sweep and write-collision flag
// Optional: define DPRAM_COLL_CNT_EN to add the saturating coll_cnt output.
module dual_port_ram_param #(
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 64,
    parameter int ADDR_W     = 6,
    parameter int RD_LATENCY = 1,
    parameter int RDW_MODE   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  ready,
    input  logic                  a_en,
    input  logic                  a_wr,
    input  logic [ADDR_W-1:0]     a_addr,
    input  logic [DATA_W-1:0]     a_wdata,
    input  logic [DATA_W/8-1:0]   a_be,
    output logic [DATA_W-1:0]     a_rdata,
    output logic                  a_rvalid,
    input  logic                  b_en,
    input  logic                  b_wr,
    input  logic [ADDR_W-1:0]     b_addr,
    input  logic [DATA_W-1:0]     b_wdata,
    input  logic [DATA_W/8-1:0]   b_be,
    output logic [DATA_W-1:0]     b_rdata,
    output logic                  b_rvalid,
`ifdef DPRAM_COLL_CNT_EN
    output logic                  collision,
    output logic [15:0]           coll_cnt
`else
    output logic                  collision
`endif
);
    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] init_addr_q, init_addr_d;

    logic              a_in_rng, b_in_rng, same_addr;
    logic              a_wr_fire, b_wr_fire, a_rd_fire, b_rd_fire, init_we;
    logic [IDX_W-1:0]  a_idx, b_idx;
    logic [DATA_W-1:0] a_word, b_word;
    logic              coll_d, coll_q;
    logic              a_s1_vld_q, b_s1_vld_q, a_rvalid_q, b_rvalid_q;
    logic [DATA_W-1:0] a_s1_data_q, b_s1_data_q, a_rdata_q, b_rdata_q;

    // Overlays the other port's same-cycle write onto a read word (new-data mode).
    function automatic logic [DATA_W-1:0] merge_wr(input logic [DATA_W-1:0] cur,
                                                   input logic hit,
                                                   input logic [NB-1:0] be,
                                                   input logic [DATA_W-1:0] wd);
        merge_wr = cur;
        if (hit) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) merge_wr[8*i +: 8] = wd[8*i +: 8];
            end
        end
    endfunction

    assign ready     = (state_q == ST_RUN);
    assign a_in_rng  = (32'(a_addr) < DEPTH);
    assign b_in_rng  = (32'(b_addr) < DEPTH);
    assign a_idx     = a_addr[IDX_W-1:0];
    assign b_idx     = b_addr[IDX_W-1:0];
    assign same_addr = (a_addr == b_addr);
    assign init_we   = (state_q == ST_INIT) && !rst;
    assign a_wr_fire = ready && !rst && a_en && a_wr && a_in_rng;
    assign b_wr_fire = ready && !rst && b_en && b_wr && b_in_rng;
    assign a_rd_fire = ready && !rst && a_en && !a_wr;
    assign b_rd_fire = ready && !rst && b_en && !b_wr;
    assign coll_d    = a_wr_fire && b_wr_fire && same_addr && ((a_be & b_be) != '0);

    always_comb begin
        a_word = a_in_rng ? mem_q[a_idx] : '0;
        b_word = b_in_rng ? mem_q[b_idx] : '0;
        if (RDW_MODE == 1) begin
            a_word = merge_wr(a_word, b_wr_fire && same_addr, b_be, b_wdata);
            b_word = merge_wr(b_word, a_wr_fire && same_addr, a_be, a_wdata);
        end
    end

    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        if (state_q == ST_INIT) begin
            init_addr_d = init_addr_q + ADDR_W'(1);
            if (init_addr_q == LAST_ADDR) begin
                state_d     = ST_RUN;
                init_addr_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            init_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            init_addr_q <= init_addr_d;
        end
    end

    // B is applied first so that A's lanes take priority on a shared address.
    always_ff @(posedge clk) begin
        if (init_we) mem_q[init_addr_q[IDX_W-1:0]] <= '0;
        for (int i = 0; i < NB; i++) begin
            if (b_wr_fire && b_be[i]) mem_q[b_idx][8*i +: 8] <= b_wdata[8*i +: 8];
            if (a_wr_fire && a_be[i]) mem_q[a_idx][8*i +: 8] <= a_wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_s1_vld_q  <= 1'b0;
            b_s1_vld_q  <= 1'b0;
            a_s1_data_q <= '0;
            b_s1_data_q <= '0;
            a_rvalid_q  <= 1'b0;
            b_rvalid_q  <= 1'b0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
            coll_q      <= 1'b0;
        end else begin
            coll_q     <= coll_d;
            a_s1_vld_q <= a_rd_fire;
            b_s1_vld_q <= b_rd_fire;
            if (a_rd_fire) a_s1_data_q <= a_word;
            if (b_rd_fire) b_s1_data_q <= b_word;
            if (RD_LATENCY == 2) begin
                a_rvalid_q <= a_s1_vld_q;
                b_rvalid_q <= b_s1_vld_q;
                if (a_s1_vld_q) a_rdata_q <= a_s1_data_q;
                if (b_s1_vld_q) b_rdata_q <= b_s1_data_q;
            end else begin
                a_rvalid_q <= a_rd_fire;
                b_rvalid_q <= b_rd_fire;
                if (a_rd_fire) a_rdata_q <= a_word;
                if (b_rd_fire) b_rdata_q <= b_word;
            end
        end
    end

    assign a_rdata   = a_rdata_q;
    assign a_rvalid  = a_rvalid_q;
    assign b_rdata   = b_rdata_q;
    assign b_rvalid  = b_rvalid_q;
    assign collision = coll_q;

`ifdef DPRAM_COLL_CNT_EN
    logic [15:0] coll_cnt_q, coll_cnt_d;

    always_comb begin
        coll_cnt_d = coll_cnt_q;
        if (coll_d && coll_cnt_q != 16'hFFFF) coll_cnt_d = coll_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) coll_cnt_q <= '0;
        else     coll_cnt_q <= coll_cnt_d;
    end

    assign coll_cnt = coll_cnt_q;
`endif

endmodule
